// File: rtl/fetch_queue_pkg.sv
// Shared widths, the fetch queue entry layout and PC helpers for the fetch front end.
// Pure declarations; no logic, no latency.
package fetch_queue_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is read combinationally from storage.
// Latency: a push is visible at the head the cycle after; push+pop when full both take effect.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign empty_o    = (count_o == '0);
    assign full       = (count_o == (AW+1)'(DEPTH));
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues imem word reads, queues {pc,instr} for decode.
// Latency: response to dec_valid is one cycle (registered enqueue). Requests stall on queue credit.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            req_fire;
    logic            credit_ok;
    logic            rsp_take;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            deq;

    logic [XLEN-1:0] tag_head;
    logic            tag_empty;
    logic [CW-1:0]   tag_count;

    fetch_entry_t    q_head;
    fetch_entry_t    q_push_dat;
    logic            q_empty;
    logic [CW-1:0]   q_count;

    // Credit counts in-flight words against free queue slots so responses always have room.
    assign credit_ok      = ((CW+1)'(q_count) + (CW+1)'(outst_q)) < (CW+1)'(DEPTH);
    assign imem_req_valid = !reset && !redirect_valid && credit_ok
                            && (outst_q < CW'(MAX_OUTST));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take = imem_rsp_valid && (outst_q != '0);
    assign rsp_drop = rsp_take && (drop_q != '0);
    assign rsp_keep = rsp_take && (drop_q == '0);

    assign dec_valid = !reset && !q_empty;
    assign dec_pc    = q_empty ? '0 : q_head.pc;
    assign dec_instr = q_empty ? '0 : q_head.instr;
    assign deq       = dec_valid && dec_ready && !redirect_valid;

    assign q_push_dat.pc    = tag_head;
    assign q_push_dat.instr = imem_rsp_data;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (req_fire),
        .push_dat_i (fetch_pc_q),
        .pop_i      (rsp_keep),
        .head_dat_o (tag_head),
        .empty_o    (tag_empty),
        .count_o    (tag_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (rsp_keep),
        .push_dat_i (q_push_dat),
        .pop_i      (deq),
        .head_dat_o (q_head),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp_take);
        if (req_fire) begin
            fetch_pc_d = next_pc(fetch_pc_q);
        end
        if (rsp_drop) begin
            drop_d = drop_q - 1'b1;
        end
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            drop_d     = outst_q - CW'(rsp_take);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (deq) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (dec_ready && !dec_valid && !redirect_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

    a_rsp_needs_outst: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outst_q != '0));

    a_tag_bound: assert property (@(posedge clk) disable iff (reset)
        (tag_count <= CW'(MAX_OUTST)) && (tag_empty == (tag_count == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-1 instruction memory model (instr = ~addr).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(32'h0), .DEPTH(4), .MAX_OUTST(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pend[$];
    bit          rsp_en;

    typedef struct {
        logic        dec_ready;
        logic        exp_dv;
        logic [31:0] exp_pc;
        logic        exp_rv;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Samples the request handshake, advances one clock and drives the memory response.
    task automatic tick();
        logic        fire;
        logic [31:0] addr;
        logic [31:0] front;
        #1;
        fire = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (fire) pend.push_back(addr);
        if (rsp_en && pend.size() > 0) begin
            front          = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~front;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          got_req;
        int          got_dec;
        logic [31:0] exp_pc;
        logic [31:0] first_addr;
        logic [31:0] dec_seen[2];
        logic [31:0] front;
        logic [31:0] exp_instr;

        vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
        vecs[2] = '{1'b1, 1'b1, 32'h0,  1'b1, 32'h8};
        vecs[3] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'hC};
        vecs[4] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h10};
        vecs[5] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h14};

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        rsp_en         = 1'b1;

        // Reset state
        #1;
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: streaming from reset, table-driven
        for (int i = 0; i < 6; i++) begin
            dec_ready = vecs[i].dec_ready;
            #1;
            exp_instr = vecs[i].exp_dv ? ~vecs[i].exp_pc : 32'h0;
            check($sformatf("t1_dec_valid[%0d]", i), 32'(dec_valid), 32'(vecs[i].exp_dv));
            check($sformatf("t1_dec_pc[%0d]", i), dec_pc, vecs[i].exp_pc);
            check($sformatf("t1_dec_instr[%0d]", i), dec_instr, exp_instr);
            check($sformatf("t1_req_valid[%0d]", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
            check($sformatf("t1_req_addr[%0d]", i), imem_req_addr, vecs[i].exp_addr);
            tick();
        end
        exp_pc = 32'h10;

        // 2: decode stalled, queue fills to DEPTH and requests stop
        dec_ready = 1'b0;
        repeat (20) tick();
        #1;
        check("t2_req_blocked", 32'(imem_req_valid), 32'h0);
        check("t2_head_pc", dec_pc, exp_pc);
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (dec_valid) begin
                check("t2_drain_pc", dec_pc, exp_pc);
                check("t2_drain_instr", dec_instr, ~exp_pc);
                exp_pc = exp_pc + 32'h4;
                n++;
            end
            tick();
        end
        check("t2_entries", 32'(n), 32'd4);
        #1;
        check("t2_resume_addr", imem_req_addr, exp_pc);
        imem_req_ready = 1'b1;

        // 3: redirect to unaligned target with two requests in flight
        rsp_en = 1'b0;
        tick();
        tick();
        #1;
        check("t3_outst_cap", 32'(imem_req_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check("t3_no_req_on_redirect", 32'(imem_req_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        got_req = 0;
        got_dec = 0;
        first_addr = '0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (imem_req_valid && imem_req_ready && got_req == 0) begin
                first_addr = imem_req_addr;
                got_req = 1;
            end
            if (dec_valid && got_dec < 2) begin
                if (dec_instr !== ~dec_pc) check("t3_instr_match", dec_instr, ~dec_pc);
                dec_seen[got_dec] = dec_pc;
                got_dec++;
            end
            tick();
        end
        check("t3_first_req", first_addr, 32'h100);
        check("t3_dec_count", 32'(got_dec), 32'd2);
        check("t3_first_dec", dec_seen[0], 32'h100);
        check("t3_second_dec", dec_seen[1], 32'h104);

        // 4: redirect coinciding with dequeue and a live response
        #1;
        check("t4_setup", 32'(dec_valid && imem_rsp_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_empty_after", 32'(dec_valid), 32'h0);
        check("t4_pc_zero", dec_pc, 32'h0);
        check("t4_req_valid", 32'(imem_req_valid), 32'h1);
        check("t4_req_addr", imem_req_addr, 32'h200);
        got_dec = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (dec_valid && got_dec == 0) begin
                check("t4_first_dec", dec_pc, 32'h200);
                check("t4_first_instr", dec_instr, ~32'h200);
                got_dec = 1;
            end
            tick();
        end
        check("t4_got_dec", 32'(got_dec), 32'h1);

        // 4b: redirect with two in flight while the first (live) response lands
        rsp_en = 1'b0;
        repeat (3) tick();
        rsp_en = 1'b1;
        front          = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~front;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        got_dec = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (dec_valid && got_dec == 0) begin
                check("t4b_first_dec", dec_pc, 32'h300);
                check("t4b_first_instr", dec_instr, ~32'h300);
                got_dec = 1;
            end
            tick();
        end
        check("t4b_got_dec", 32'(got_dec), 32'h1);

        // 5: reset mid-burst
        dec_ready = 1'b0;
        rsp_en    = 1'b0;
        repeat (3) tick();
        #1;
        check("t5_setup", 32'(dec_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("t5_dec_valid", 32'(dec_valid), 32'h0);
        check("t5_req_valid", 32'(imem_req_valid), 32'h0);
        check("t5_dec_pc", dec_pc, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEADBEEF;
        tick();
        tick();
        reset = 1'b0;
        pend.delete();
        rsp_en    = 1'b1;
        dec_ready = 1'b1;
        #1;
        check("t5_restart_addr", imem_req_addr, 32'h0);
        check("t5_restart_valid", 32'(imem_req_valid), 32'h1);
        got_dec = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (dec_valid && got_dec == 0) begin
                check("t5_first_dec", dec_pc, 32'h0);
                check("t5_first_instr", dec_instr, ~32'h0);
                got_dec = 1;
            end
            tick();
        end
        check("t5_got_dec", 32'(got_dec), 32'h1);

`ifdef FETCH_PERF_EN
        // 6: 3 starved cycles then 10 deliveries
        reset = 1'b1;
        #1;
        check("t6_rst_fetched", perf_fetched, 32'h0);
        check("t6_rst_stall", perf_stall, 32'h0);
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;
        tick();
        reset = 1'b0;
        pend.delete();
        tick();
        imem_req_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (dec_valid && dec_ready) n++;
            tick();
            if (n == 10) dec_ready = 1'b0;
        end
        #1;
        check("t6_perf_fetched", perf_fetched, 32'd10);
        check("t6_perf_stall", perf_stall, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
